// File: rtl/usb_phy_pkg.sv
// Shared USB PHY definitions: symbol width, K28.5 comma codes and the
// aligner state encoding.
package usb_phy_pkg;
    localparam int SYM_W = 10;

    localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;
    localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    function automatic logic is_k28_5(input logic [SYM_W-1:0] sym);
        return (sym == K28_5_RDN) || (sym == K28_5_RDP);
    endfunction

    // Symbol starting k bits into the two-word window (bit 19 = oldest bit).
    function automatic logic [SYM_W-1:0] window_sym(input logic [2*SYM_W-1:0] win,
                                                    input logic [3:0]         k);
        logic [2*SYM_W-1:0] sh;
        sh = win << k;
        return sh[2*SYM_W-1:SYM_W];
    endfunction
endpackage

// File: rtl/usb_comma_detect.sv
// Combinational K28.5 search over all ten bit offsets of a 20-bit window;
// the lowest matching offset wins.
module usb_comma_detect
    import usb_phy_pkg::*;
(
    input  logic [2*SYM_W-1:0] win,
    output logic               hit,
    output logic [3:0]         offset
);
    logic [SYM_W-1:0] match;

    for (genvar k = 0; k < SYM_W; k++) begin : g_cand
        assign match[k] = is_k28_5(win[2*SYM_W-1-k -: SYM_W]);
    end

    always_comb begin
        hit    = |match;
        offset = '0;
        // Scan downwards so the lowest matching offset is the last written.
        for (int k = SYM_W-1; k >= 0; k--) begin
            if (match[k]) offset = 4'(k);
        end
    end
endmodule

// File: rtl/usb_comma_align.sv
// 10-bit comma aligner: hunts for K28.5, confirms it LOCK_CNT times at one
// offset, then emits symbol-aligned words until LOSS_CNT misaligned commas.
module usb_comma_align
    import usb_phy_pkg::*;
#(
    parameter int LOCK_CNT = 2,
    parameter int LOSS_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [SYM_W-1:0] in_data,
    input  logic             in_valid,
    output logic [SYM_W-1:0] out_data,
    output logic             out_valid,
    output logic             locked,
    output logic             comma_det,
    output logic [3:0]       align_offset,
    output logic             realign
);
    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

    align_state_t       state;
    logic [SYM_W-1:0]   prev_word;
    logic [2:0]         cnt;
    logic [2:0]         miss_cnt;
    logic [3:0]         cand_off;
    logic [2*SYM_W-1:0] win;
    logic               hit;
    logic [3:0]         det_off;
    logic               at_cand;
    logic               at_align;
    logic               lock_now;
    logic               out_en;
    logic [3:0]         out_off;
    logic [SYM_W-1:0]   out_word;

    assign win = {prev_word, in_data};

    usb_comma_detect u_detect (
        .win    (win),
        .hit    (hit),
        .offset (det_off)
    );

    assign at_cand  = is_k28_5(window_sym(win, cand_off));
    assign at_align = is_k28_5(window_sym(win, align_offset));

    // Lock taken this cycle: the word is already emitted with the new offset.
    assign lock_now = in_valid && !clr &&
                      (((state == HUNT) && hit && (LOCK_CNT == 1)) ||
                       ((state == CHECK) && at_cand && (({1'b0, cnt} + 4'd1) >= LOCK_N)));
    assign out_off  = !lock_now ? align_offset : (state == HUNT) ? det_off : cand_off;
    assign out_word = window_sym(win, out_off);
    assign out_en   = in_valid && ((state == LOCKED) || lock_now);
    assign locked   = (state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HUNT;
            prev_word    <= '0;
            cnt          <= '0;
            miss_cnt     <= '0;
            cand_off     <= '0;
            align_offset <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            comma_det    <= 1'b0;
            realign      <= 1'b0;
        end else begin
            realign <= 1'b0;
            if (in_valid) prev_word <= in_data;
            if (clr) begin
                state     <= HUNT;
                cnt       <= '0;
                miss_cnt  <= '0;
                out_valid <= 1'b0;
                comma_det <= 1'b0;
            end else begin
                out_valid <= out_en;
                comma_det <= out_en && is_k28_5(out_word);
                if (out_en) out_data <= out_word;
                if (in_valid && hit) begin
                    case (state)
                        HUNT: begin
                            cand_off <= det_off;
                            cnt      <= 3'd1;
                            if (lock_now) begin
                                state        <= LOCKED;
                                align_offset <= det_off;
                                miss_cnt     <= '0;
                            end else begin
                                state <= CHECK;
                            end
                        end
                        CHECK: begin
                            if (at_cand) begin
                                cnt <= (cnt == 3'd7) ? cnt : cnt + 3'd1;
                                if (lock_now) begin
                                    state        <= LOCKED;
                                    align_offset <= cand_off;
                                    miss_cnt     <= '0;
                                end
                            end else begin
                                cand_off <= det_off;
                                cnt      <= 3'd1;
                            end
                        end
                        LOCKED: begin
                            if (at_align) begin
                                miss_cnt <= '0;
                            end else if (({1'b0, miss_cnt} + 4'd1) >= LOSS_N) begin
                                state    <= HUNT;
                                miss_cnt <= '0;
                                realign  <= 1'b1;
                            end else begin
                                miss_cnt <= miss_cnt + 3'd1;
                            end
                        end
                        default: state <= HUNT;
                    endcase
                end
            end
        end
    end
endmodule

// File: doc/usb_comma_align.md
USB_COMMA_ALIGN -- requirements
Module: usb_comma_align

Interface
REQ-001 Parameter LOCK_CNT, default 2: consecutive commas at one offset required to declare lock; legal range 1..7.
REQ-002 Parameter LOSS_CNT, default 4: consecutive misaligned commas while locked that force re-hunt; legal range 1..7.
REQ-003 clk  in  1  word clock (recovered clock divided by 10); every register updates on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 clr  in  1  synchronous clear; return to HUNT.
REQ-006 in_data  in  10  unaligned parallel word from the serial-to-parallel stage; bit 9 is the first-received bit.
REQ-007 in_valid  in  1  in_data is a new word this cycle.
REQ-008 out_data  out  10  symbol-aligned word; bit 9 is the first-received bit.
REQ-009 out_valid  out  1  out_data is valid.
REQ-010 locked  out  1  aligner is in LOCKED.
REQ-011 comma_det  out  1  aligned K28.5 present on out_data.
REQ-012 align_offset  out  4  current bit offset, 0..9.
REQ-013 realign  out  1  one-cycle pulse on loss of lock.

Function
REQ-014 prev_word register: loads in_data on every in_valid=1 cycle; holds otherwise.
REQ-015 Window W[19:0] = {prev_word, in_data}; candidate(k) = W[19-k:10-k], for k=0..9.
REQ-016 Comma detection: candidate(k) equals 10'b0011111010 (RD-) or 10'b1100000101 (RD+); evaluated only when in_valid=1.
REQ-017 Multiple offsets match in one cycle: the lowest k wins.
REQ-018 States: HUNT, CHECK, LOCKED; encoded as a 2-bit enum.
REQ-019 HUNT, comma at offset k: cand_off=k, cnt=1; next state is LOCKED if LOCK_CNT=1, otherwise CHECK.
REQ-020 CHECK, comma at cand_off: cnt+1; when cnt reaches LOCK_CNT, go to LOCKED and set align_offset=cand_off.
REQ-021 CHECK, comma at any other offset: cand_off=new k, cnt=1; stay in CHECK.
REQ-022 LOCKED, comma at align_offset: miss_cnt=0.
REQ-023 LOCKED, comma only at other offsets: miss_cnt+1; at LOSS_CNT, go to HUNT, clear miss_cnt, and assert realign for 1 cycle.
REQ-024 A non-comma word never changes state or counters.
REQ-025 out_data/out_valid/comma_det are registered, latency 1 cycle:
- out_data = candidate(align_offset).
- out_valid = in_valid AND the state at sampling time is LOCKED (this includes the cycle on which the lock transition occurs, using the new offset).
REQ-026 In HUNT/CHECK: out_valid=0 and out_data holds its last value.
REQ-027 clr=1 takes priority over all detection: next state HUNT; cnt, miss_cnt, out_valid and realign are cleared; align_offset is held.
REQ-028 in_valid=0: all state, counters and prev_word hold; out_valid=0 the next cycle.
REQ-029 Counters are 3-bit and saturate; they never wrap.

Reset
REQ-030 rst_n=0 forces immediately:
- state=HUNT; prev_word=0; cnt=0; miss_cnt=0.
- align_offset=0; out_data=0; out_valid=0; locked=0; comma_det=0; realign=0.
REQ-031 Reset release mid-stream: hunting restarts from the first in_valid word; the first word is compared against prev_word=0.

Structure
REQ-032 Shared package usb_phy_pkg holds:
- state enum;
- K28.5 RD-/RD+ constants;
- symbol width 10.
REQ-033 One sub-module, usb_comma_detect: combinational 20-bit window to {hit, offset[3:0]} with lowest-k priority; the FSM and output registers stay in usb_comma_align.

Verification
REQ-034 Stream shifted 3 bits containing K28.5 RD- every 4th word, LOCK_CNT=2 -> locked=1 after the 2nd comma; align_offset=3; out_data matches the transmitted symbols with 1-cycle latency.
REQ-035 Aligned stream (offset 0) with alternating RD-/RD+ commas -> lock at offset 0; comma_det pulses at each comma; out_valid matches in_valid delayed by 1.
REQ-036 Locked at offset 3, then 4 commas at offset 7 -> realign pulse on the 4th; state HUNT; relock at 7 after 2 more commas.
REQ-037 CHECK with candidate 3, next comma at offset 5 -> cand_off=5, cnt=1; no lock until a second comma at 5.
REQ-038 rst_n pulsed low mid-LOCKED (asynchronous, between edges) -> all outputs read 0 immediately; clr=1 while LOCKED -> HUNT on the next edge, out_valid=0.
REQ-039 in_valid deasserted for 5 cycles while locked -> state and offset unchanged; out_valid=0 for those cycles; alignment resumes correctly.
